// File: rtl/lsu_pkg.sv
// LSU shared definitions: FSM encodings, RISC-V load/store funct3
// values, access-size codes and the access legality check.
package lsu_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   function automatic logic acc_legal(
      input logic [2:0] f3,
      input logic       we,
      input logic [2:0] off,
      input logic       x64
   );
      logic [2:0] am;
      logic       ok;
      unique case (f3[1:0])
         SZ_B:    am = 3'b000;
         SZ_H:    am = 3'b001;
         SZ_W:    am = 3'b011;
         default: am = 3'b111;
      endcase
      ok = 1'b1;
      if (!x64 && f3[1:0] == SZ_D) ok = 1'b0;
      if (we && f3[2])             ok = 1'b0;
      if (!x64 && f3 == F3_LWU)    ok = 1'b0;
      if ((off & am) != 3'b000)    ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU data-bus interface: request handshake plus response channel.
interface lsu_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [XLEN/8-1:0] be;
   logic [XLEN-1:0]   wdata;
   logic              rvalid;
   logic [XLEN-1:0]   rdata;
   logic              err;

   modport master (
      output valid, addr, we, be, wdata,
      input  ready, rvalid, rdata, err
   );

   modport slave (
      input  valid, addr, we, be, wdata,
      output ready, rvalid, rdata, err
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane placement for stores and lane extraction plus
// sign/zero extension for loads; purely combinational.
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int NB   = XLEN / 8,
   localparam int OW   = $clog2(NB)
) (
   input  logic [2:0]      funct3_i,
   input  logic [OW-1:0]   off_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [NB-1:0]   be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [7:0]      m8;
   logic [XLEN-1:0] sh;
   logic            msb;
   int              nb;
   int              nbits;

   always_comb begin
      nb = 1 << funct3_i[1:0];
      unique case (funct3_i[1:0])
         SZ_B:    m8 = 8'h01;
         SZ_H:    m8 = 8'h03;
         SZ_W:    m8 = 8'h0F;
         default: m8 = 8'hFF;
      endcase
      be_o = NB'(m8) << off_i;
      // every lane of the access size carries the low bytes of the store
      for (int i = 0; i < NB; i++)
         wdata_o[8*i +: 8] = wdata_i[8*(i & (nb - 1)) +: 8];
      sh    = rdata_i >> {off_i, 3'b000};
      nbits = (8 * nb > XLEN) ? XLEN : 8 * nb;
      msb   = sh[nbits-1] & ~funct3_i[2];
      for (int j = 0; j < XLEN; j++)
         rdata_o[j] = (j < nbits) ? sh[j] : msb;
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: checks legality, drives one
// bus request, waits for the response and pulses done for one cycle.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic              err_o,
   output logic [XLEN-1:0]   rdata_o,
   lsu_if.master             bus
);

   localparam int NB    = XLEN / 8;
   localparam int OW    = $clog2(NB);
   localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;

   logic [NB-1:0]     be_c;
   logic [XLEN-1:0]   wlane_c;
   logic [XLEN-1:0]   rext_c;
   logic              legal_c;
   logic              tmo_c;
   logic [CW-1:0]     cnt_inc;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3_i (f3_q),
      .off_i    (addr_q[OW-1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (bus.rdata),
      .be_o     (be_c),
      .wdata_o  (wlane_c),
      .rdata_o  (rext_c)
   );

   assign legal_c = acc_legal(funct3_i, we_i, addr_i[2:0], XLEN == 64);
   assign tmo_c   = (TIMEOUT != 0) && (cnt_q == CW'(TO_M1));
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i && legal_c) begin
               state_d = ST_REQ;
               cnt_d   = '0;
               we_d    = we_i;
               f3_d    = funct3_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
            end else if (req_i) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_inc;
            if (bus.ready && we_q) begin
               state_d = ST_DONE;
               err_d   = bus.err;
               rdata_d = '0;
            end else if (bus.ready) begin
               state_d = ST_RESP;
            end else if (tmo_c) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ST_RESP: begin
            cnt_d = cnt_inc;
            if (bus.rvalid) begin
               state_d = ST_DONE;
               err_d   = bus.err;
               rdata_d = bus.err ? '0 : rext_c;
            end else if (tmo_c) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
            rdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // err/rdata registers are only non-zero while in DONE
   assign done_o    = (state_q == ST_DONE);
   assign err_o     = err_q;
   assign rdata_o   = rdata_q;
   assign stall_o   = req_i & ~done_o;
   assign bus.valid = (state_q == ST_REQ);
   assign bus.addr  = {addr_q[ADDR_W-1:OW], OW'(0)};
   assign bus.we    = bus.valid & we_q;
   assign bus.be    = bus.valid ? be_c : '0;
   assign bus.wdata = bus.valid ? wlane_c : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: XLEN=32 with TIMEOUT=4 and XLEN=64 with
// default timeout, driven through the bus interface.
module tb_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32, req32, we32, stall32, done32, err32;
   logic [2:0]  f3_32;
   logic [31:0] addr32, wd32, rd32;
   logic        rst64, req64, we64, stall64, done64, err64;
   logic [2:0]  f3_64;
   logic [31:0] addr64;
   logic [63:0] wd64, rd64;

   lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();

   lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst(rst32), .req_i(req32), .we_i(we32),
      .funct3_i(f3_32), .addr_i(addr32), .wdata_i(wd32),
      .stall_o(stall32), .done_o(done32), .err_o(err32),
      .rdata_o(rd32), .bus(b32)
   );

   lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst64), .req_i(req64), .we_i(we64),
      .funct3_i(f3_64), .addr_i(addr64), .wdata_i(wd64),
      .stall_o(stall64), .done_o(done64), .err_o(err64),
      .rdata_o(rd64), .bus(b64)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string t, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", t, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic ld32(input string t, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rdat,
                       input logic [3:0] be, input logic berr,
                       input logic [31:0] exp);
      req32 = 1; we32 = 0; f3_32 = f3; addr32 = a;
      tick; smp;
      chk({t, "_valid"}, b32.valid, 1);
      chk({t, "_be"}, b32.be, be);
      chk({t, "_addr"}, b32.addr, a & 32'hFFFF_FFFC);
      b32.ready = 1;
      tick;
      b32.ready = 0; b32.rvalid = 1; b32.rdata = rdat; b32.err = berr;
      smp;
      chk({t, "_resp_valid"}, b32.valid, 0);
      chk({t, "_resp_done"}, done32, 0);
      tick;
      b32.rvalid = 0; b32.err = 0;
      smp;
      chk({t, "_done"}, done32, 1);
      chk({t, "_err"}, err32, berr);
      chk({t, "_rdata"}, rd32, exp);
      chk({t, "_stall"}, stall32, 0);
      req32 = 0;
      tick; smp;
      chk({t, "_pulse"}, done32, 0);
   endtask

   task automatic st32(input string t, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] wexp,
                       input logic berr);
      req32 = 1; we32 = 1; f3_32 = f3; addr32 = a; wd32 = wd;
      tick; smp;
      chk({t, "_valid"}, b32.valid, 1);
      chk({t, "_we"}, b32.we, 1);
      chk({t, "_be"}, b32.be, be);
      chk({t, "_wdata"}, b32.wdata, wexp);
      b32.ready = 1; b32.err = berr; b32.rvalid = 1;
      tick;
      b32.ready = 0; b32.err = 0; b32.rvalid = 0;
      smp;
      chk({t, "_done"}, done32, 1);
      chk({t, "_err"}, err32, berr);
      chk({t, "_rdata"}, rd32, 0);
      req32 = 0; we32 = 0;
      tick; smp;
      chk({t, "_pulse"}, done32, 0);
   endtask

   task automatic il32(input string t, input logic w,
                       input logic [2:0] f3, input logic [31:0] a);
      req32 = 1; we32 = w; f3_32 = f3; addr32 = a;
      #1;
      chk({t, "_stall"}, stall32, 1);
      tick; smp;
      chk({t, "_valid"}, b32.valid, 0);
      chk({t, "_done"}, done32, 1);
      chk({t, "_err"}, err32, 1);
      chk({t, "_rdata"}, rd32, 0);
      req32 = 0; we32 = 0;
      tick; smp;
      chk({t, "_pulse"}, done32, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst32 = 1; req32 = 0; we32 = 0; f3_32 = 0; addr32 = 0; wd32 = 0;
      rst64 = 1; req64 = 0; we64 = 0; f3_64 = 0; addr64 = 0; wd64 = 0;
      b32.ready = 0; b32.rvalid = 0; b32.rdata = 0; b32.err = 0;
      b64.ready = 0; b64.rvalid = 0; b64.rdata = 0; b64.err = 0;
      smp;
      chk("rst_valid", b32.valid, 0);
      chk("rst_done", done32, 0);
      chk("rst_err", err32, 0);
      chk("rst_rdata", rd32, 0);
      chk("rst_stall", stall32, 0);
      chk("rst_valid64", b64.valid, 0);
      tick;
      rst32 = 0; rst64 = 0;
      tick; smp;

      ld32("lb", F3_LB, 32'h103, 32'h8012_3456, 4'b1000, 0,
           32'hFFFF_FF80);
      ld32("lhu", F3_LHU, 32'h102, 32'h8001_ABCD, 4'b1100, 0,
           32'h0000_8001);
      ld32("lh", F3_LH, 32'h100, 32'h1234_F00D, 4'b0011, 0,
           32'hFFFF_F00D);
      ld32("lw_err", F3_LW, 32'h104, 32'hDEAD_BEEF, 4'b1111, 1, 0);
      st32("sh", F3_SH, 32'h102, 32'h0000_1234, 4'b1100,
           32'h1234_1234, 0);
      st32("sb", F3_SB, 32'h101, 32'h0000_00AB, 4'b0010,
           32'hABAB_ABAB, 1);
      st32("sw", F3_SW, 32'h108, 32'hCAFE_F00D, 4'b1111,
           32'hCAFE_F00D, 0);
      il32("lw_mis", 0, F3_LW, 32'h101);
      il32("sh_mis", 1, F3_SH, 32'h103);
      il32("ld_x32", 0, F3_LD, 32'h0);
      il32("st_u", 1, F3_LBU, 32'h0);
      il32("lwu_x32", 0, F3_LWU, 32'h0);

      // timeout: ready never arrives, 4 REQ cycles then error
      req32 = 1; we32 = 0; f3_32 = F3_LW; addr32 = 32'h200;
      tick;
      for (int i = 0; i < 4; i++) begin
         smp;
         chk("tmo_valid", b32.valid, 1);
         chk("tmo_early", done32, 0);
         tick;
      end
      smp;
      chk("tmo_done", done32, 1);
      chk("tmo_err", err32, 1);
      chk("tmo_drop", b32.valid, 0);
      req32 = 0;
      tick; smp;

      // XLEN=64 LWU from upper word
      req64 = 1; we64 = 0; f3_64 = F3_LWU; addr64 = 32'h4;
      tick; smp;
      chk("lwu_be", b64.be, 8'hF0);
      chk("lwu_addr", b64.addr, 0);
      b64.ready = 1;
      tick;
      b64.ready = 0; b64.rvalid = 1; b64.rdata = 64'hFFFF_FFFF_0000_0000;
      tick;
      b64.rvalid = 0;
      smp;
      chk("lwu_done", done64, 1);
      chk("lwu_rdata", rd64, 64'h0000_0000_FFFF_FFFF);
      req64 = 0;
      tick; smp;

      // reset while REQ is presenting a request
      req64 = 1; f3_64 = F3_LD; addr64 = 32'h8;
      tick; smp;
      chk("ld_be", b64.be, 8'hFF);
      rst64 = 1;
      #1;
      chk("rreq_valid", b64.valid, 0);
      chk("rreq_be", b64.be, 0);
      req64 = 0;
      tick;
      rst64 = 0;
      tick; smp;

      // reset while waiting in RESP, then stray rvalid in IDLE
      req64 = 1;
      tick; smp;
      b64.ready = 1;
      tick;
      b64.ready = 0;
      smp;
      chk("rresp_pre", b64.valid, 0);
      rst64 = 1; b64.rvalid = 1; b64.rdata = 64'h1;
      #1;
      chk("rresp_done", done64, 0);
      chk("rresp_valid", b64.valid, 0);
      req64 = 0;
      tick;
      rst64 = 0;
      tick; smp;
      chk("stray_rvalid", done64, 0);
      b64.rvalid = 0;
      req64 = 1;
      tick; smp;
      chk("post_rst_accept", b64.valid, 1);
      req64 = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 255, max wait cycles per transaction; 0 SHALL disable timeout.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  core memory request, held until done_o.
REQ-007 we_i  in  1  1=store, 0=load.
REQ-008 funct3_i  in  3  RISC-V load/store funct3.
REQ-009 addr_i  in  ADDR_W  byte address.
REQ-010 wdata_i  in  XLEN  store data, LSB-aligned.
REQ-011 stall_o  out  1  core SHALL freeze PC while high.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 err_o  out  1  error qualifier, valid only with done_o.
REQ-014 rdata_o  out  XLEN  extended load result, valid with done_o.
REQ-015 bus_valid_o / bus_ready_i  out/in  1  request handshake.
REQ-016 bus_addr_o  out  ADDR_W  address, low log2(XLEN/8) bits zero.
REQ-017 bus_we_o, bus_be_o, bus_wdata_o  out  1, XLEN/8, XLEN  write strobe, byte enables, lane-placed data.
REQ-018 bus_rvalid_i, bus_rdata_i, bus_err_i  in  1, XLEN, 1  response valid, data, error.

Function
REQ-019 FSM states IDLE, REQ, RESP, DONE.
REQ-020 Access size SHALL be 2^funct3_i[1:0] bytes; funct3_i[2]=1 SHALL mean zero-extend (loads only).
REQ-021 Illegal: size 8 with XLEN=32, store with funct3_i[2]=1, LWU with XLEN=32, addr not size-aligned.
REQ-022 IDLE, req_i=1, legal -> REQ; bus_valid_o=1 with addr, be, we, wdata stable until handshake.
REQ-023 IDLE, req_i=1, illegal -> DONE; no bus transaction; err_o=1.
REQ-024 REQ, bus_valid_o & bus_ready_i: store -> DONE, err_o=bus_err_i; load -> RESP.
REQ-025 RESP, bus_rvalid_i -> DONE; rdata_o captured, err_o=bus_err_i.
REQ-026 DONE: done_o=1 for exactly one cycle -> IDLE; req_i SHALL NOT be accepted in DONE.
REQ-027 stall_o = req_i & ~done_o (combinational).
REQ-028 bus_be_o = size mask << addr_i[log2(XLEN/8)-1:0]; bus_wdata_o = wdata_i low bytes replicated into every size lane.
REQ-029 rdata_o = selected lane sign- or zero-extended to XLEN; rdata_o SHALL be 0 when err_o=1.
REQ-030 Counter SHALL clear on entering REQ, increment in REQ/RESP, saturate; reaching TIMEOUT -> DONE with err_o=1, bus_valid_o dropped.
REQ-031 bus_rvalid_i outside RESP SHALL be ignored.

Reset
REQ-032 rst SHALL immediately force IDLE, counter 0, and all outputs 0, including bus_valid_o mid-transaction.
REQ-033 First acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum, funct3 encodings, and size constants.
REQ-035 Lane placement/extraction and sign extension SHALL be in combinational sub-module lsu_align.

Verification
REQ-036 XLEN=32, LB addr 0x103, bus_rdata_i 0x80xxxxxx, ready and rvalid 1 cycle each -> bus_be_o 4'b1000, rdata_o 0xFFFFFF80, done_o 3 cycles after req_i.
REQ-037 SH addr 0x102, wdata 0x1234 -> bus_be_o 4'b1100, bus_wdata_o 0x12341234, done_o without RESP.
REQ-038 LW addr 0x101 -> no bus_valid_o, done_o and err_o next cycle, rdata_o 0.
REQ-039 TIMEOUT=4, bus_ready_i held 0 -> err_o with done_o after 4 REQ cycles.
REQ-040 XLEN=64, LWU addr 0x4, rdata 0xFFFFFFFF_00000000 -> rdata_o 0x00000000_FFFFFFFF; rst mid-RESP -> bus_valid_o 0 and IDLE immediately.
